axis_fir_sink: RTL and testbench

- AXI-Stream receiver for the 32-bit FIR compiler output port (m_axis_data_*).
- Each accepted sample is rescaled to a 16-bit signed sample with saturation and buffered in a small FIFO.
- Samples are then re-framed with tlast every FRAME_LEN samples.
- Sits downstream of the fir_compiler instances and feeds capture/DMA logic.
- Exerts backpressure on the filter via s_axis_data_tready.

---
 rtl/axis_fir_pkg.sv | 42 ++++
 rtl/axis_sync_fifo.sv | 50 +++++
 rtl/axis_fir_sink.sv | 123 ++++++++++++
 tb/tb_axis_fir_sink.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fir_pkg.sv
// rtl/axis_fir_pkg.sv - shared widths, FIFO entry type and saturating shift helper
package axis_fir_pkg;

  localparam int DIN_W_DEF  = 32;
  localparam int DOUT_W_DEF = 16;
  // Working width for the shift/clamp helper; wide enough for DIN_W+1 bits.
  localparam int SAT_W      = 64;

  typedef struct packed {
    logic                  last;
    logic [DOUT_W_DEF-1:0] sample;
  } fifo_entry_t;

  typedef struct packed {
    logic             ovf;
    logic [SAT_W-1:0] val;
  } sat_res_t;

  // Arithmetic right shift followed by clamping to a signed dout_w range.
  function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] din,
                                         input int                      shift,
                                         input int                      dout_w);
    logic signed [SAT_W-1:0] y;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                res;
    y       = din >>> shift;
    hi      = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (dout_w - 1));
    res.ovf = 1'b0;
    res.val = y;
    if (y > hi) begin
      res.val = hi;
      res.ovf = 1'b1;
    end else if (y < lo) begin
      res.val = lo;
      res.ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module axis_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == PW'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted write/read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge aclk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axis_fir_sink.sv
// rtl/axis_fir_sink.sv - FIR output rescale/saturate, buffer and re-frame; AXIS_FIR_SINK_ROUND_EN selects round-half-up
module axis_fir_sink
  import axis_fir_pkg::*;
#(
  parameter int DIN_W      = DIN_W_DEF,
  parameter int DOUT_W     = DOUT_W_DEF,
  parameter int SHIFT      = 15,
  parameter int FRAME_LEN  = 1000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DIN_W-1:0]  s_axis_data_tdata,
  input  logic              s_axis_data_tvalid,
  output logic              s_axis_data_tready,
  output logic [DOUT_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              sat_flag,
  output logic [15:0]       frame_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  logic                    s_ready_q;
  logic                    accept;
  logic signed [SAT_W-1:0] din_ext;
  logic signed [SAT_W-1:0] din_adj;
  sat_res_t                sat_r;

  logic                    s1_valid;
  logic                    s1_last;
  logic [DOUT_W-1:0]       s1_sample;
  logic [IW-1:0]           in_idx;

  logic [DOUT_W:0]         fifo_head;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic                    pop;
  logic [CW:0]             occ_next;

  assign accept  = s_axis_data_tvalid & s_ready_q;
  assign din_ext = SAT_W'($signed(s_axis_data_tdata));

`ifdef AXIS_FIR_SINK_ROUND_EN
  // Adding half an LSB before the floor shift gives round-half-up; the wide
  // working width keeps the most positive input from wrapping.
  assign din_adj = din_ext + (SAT_W'(1) <<< (SHIFT - 1));
`else
  assign din_adj = din_ext;
`endif

  assign sat_r = sat_shift(din_adj, SHIFT, DOUT_W);

  // Stage 1: capture the rescaled sample, its frame position and saturation.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sample <= '0;
      in_idx    <= '0;
      sat_flag  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sample <= DOUT_W'(sat_r.val);
        s1_last   <= (in_idx == LAST_IDX);
        in_idx    <= (in_idx == LAST_IDX) ? '0 : in_idx + IW'(1);
        if (sat_r.ovf) sat_flag <= 1'b1;
      end
    end
  end

  // Stage 1 always drains into the FIFO; ready throttling guarantees room.
  axis_sync_fifo #(
    .WIDTH (DOUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (s1_valid),
    .wr_data ({s1_last, s1_sample}),
    .rd_en   (m_axis_tready),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign pop           = m_axis_tready & ~fifo_empty;
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_head[DOUT_W-1:0];
  assign m_axis_tlast  = fifo_empty ? 1'b0 : fifo_head[DOUT_W];

  // Occupancy (FIFO plus stage 1) as it will stand after this edge.
  assign occ_next = {1'b0, fifo_count}
                  + {{CW{1'b0}}, s1_valid}
                  + {{CW{1'b0}}, accept}
                  - {{CW{1'b0}}, pop};

  // Registered ready: only offer a slot when the next sample is sure to fit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_ready_q <= 1'b0;
    end else begin
      s_ready_q <= (occ_next < (CW + 1)'(FIFO_DEPTH));
    end
  end

  assign s_axis_data_tready = s_ready_q;

  // Count completed frames as their last sample leaves.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt <= 16'd0;
    end else if (pop && fifo_head[DOUT_W]) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_fir_sink.sv
// tb/tb_axis_fir_sink.sv - randomized self-checking bench for axis_fir_sink
module tb_axis_fir_sink;

  localparam int DIN_W      = 32;
  localparam int DOUT_W     = 16;
  localparam int SHIFT      = 15;
  localparam int FRAME_LEN  = 1000;
  localparam int FIFO_DEPTH = 16;

  logic        aclk     = 1'b0;
  logic        aresetn  = 1'b0;
  logic [31:0] s_tdata  = 32'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        sat_flag;
  logic [15:0] frame_cnt;

  always #5 aclk = ~aclk;

  axis_fir_sink #(
    .DIN_W      (DIN_W),
    .DOUT_W     (DOUT_W),
    .SHIFT      (SHIFT),
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_tdata       (m_tdata),
    .m_axis_tvalid      (m_tvalid),
    .m_axis_tready      (m_tready),
    .m_axis_tlast       (m_tlast),
    .sat_flag           (sat_flag),
    .frame_cnt          (frame_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [16:0] exp_q[$];
  logic [15:0] out_log[$];
  int          in_idx_m;
  int          exp_frames;
  int          acc_cnt = 0;
  int          out_cnt;
  int          last_cnt;
  int          first_last_idx;
  bit          exp_sat;
  bit          held;
  logic [16:0] held_val;
  logic [16:0] mon_e;
  logic [15:0] mon_y;
  bit          mon_ovf;

  // Scale by 2^-SHIFT with floor (or round-half-up), then clamp to int16.
  function automatic logic [15:0] model_scale(input logic [31:0] x, output bit ovf);
    longint v;
    longint y;
    longint d;
    d = 64'd1 << SHIFT;
    v = longint'($signed(x));
`ifdef AXIS_FIR_SINK_ROUND_EN
    v = v + d / 2;
`endif
    if (v >= 0) y = v / d;
    else        y = -((-v + d - 1) / d);
    ovf = 1'b0;
    if (y > 32767) begin
      y = 32767;
      ovf = 1'b1;
    end else if (y < -32768) begin
      y = -32768;
      ovf = 1'b1;
    end
    return y[15:0];
  endfunction

  function automatic logic [31:0] nominal();
    logic [31:0] r;
    r = $urandom;
    return {{2{r[29]}}, r[29:0]};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    out_log.delete();
    in_idx_m       = 0;
    exp_frames     = 0;
    exp_sat        = 1'b0;
    held           = 1'b0;
    out_cnt        = 0;
    last_cnt       = 0;
    first_last_idx = -1;
  endtask

  // Monitor: inputs and outputs are stable at the falling edge.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (held) check_eq("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, held_val});
      held     = m_tvalid && !m_tready;
      held_val = {m_tlast, m_tdata};
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", m_tvalid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("out_sample", {m_tlast, m_tdata}, mon_e);
          if (mon_e[16]) exp_frames++;
        end
        out_log.push_back(m_tdata);
        if (m_tlast) begin
          last_cnt++;
          if (first_last_idx < 0) first_last_idx = out_cnt;
        end
        out_cnt++;
      end
      if (s_tvalid && s_tready) begin
        mon_y = model_scale(s_tdata, mon_ovf);
        exp_q.push_back({(in_idx_m == FRAME_LEN - 1), mon_y});
        in_idx_m = (in_idx_m + 1) % FRAME_LEN;
        if (mon_ovf) exp_sat = 1'b1;
        acc_cnt++;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic do_reset(input int n);
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    model_clear();
    repeat (n) @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_s_tready", s_tready, 1'b0);
    check_eq("rst_m_tvalid", m_tvalid, 1'b0);
    check_eq("rst_m_tdata", m_tdata, 16'h0000);
    check_eq("rst_m_tlast", m_tlast, 1'b0);
    check_eq("rst_sat_flag", sat_flag, 1'b0);
    check_eq("rst_frame_cnt", frame_cnt, 16'h0000);
    aresetn = 1'b1;
    #1;
    check_eq("rdy_before_edge", s_tready, 1'b0);
    @(negedge aclk);
    check_eq("rdy_first_edge", s_tready, 1'b1);
    @(posedge aclk);
    #1;
  endtask

  // Present one sample and hold it until accepted; tvalid stays high.
  task automatic drive_sample(input logic [31:0] d);
    int guard;
    guard    = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_tready && guard < 2000) begin
      @(negedge aclk);
      guard++;
    end
    if (!s_tready) check_eq("drv_timeout", s_tready, 1'b1);
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tdata  = $urandom;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    int g;
    g        = 0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    while ((exp_q.size() != 0 || m_tvalid) && g < 500) begin
      @(negedge aclk);
      g++;
    end
    repeat (2) @(negedge aclk);
    check_eq("drain_empty", exp_q.size(), 0);
    check_eq("drain_tvalid", m_tvalid, 1'b0);
    check_eq("frame_cnt", frame_cnt, exp_frames[15:0]);
    check_eq("sat_flag", sat_flag, exp_sat);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int base_acc;
    int base_out;
    bit done_t;

    model_clear();
    do_reset(10);

    // Latency and scaling
    m_tready = 1'b1;
    s_tdata  = 32'h0001_0000;
    s_tvalid = 1'b1;
    @(negedge aclk);
    check_eq("lat_ready", s_tready, 1'b1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tdata  = $urandom;
    lat = 1;
    @(negedge aclk);
    while (!m_tvalid && lat < 10) begin
      @(posedge aclk);
      lat++;
      @(negedge aclk);
    end
    check_eq("latency", lat, 2);
    @(posedge aclk);
    #1;
    drive_sample(32'hFFFF_0000);
    drive_sample(32'h0000_4000);
    idle(1);
    drain();
    check_eq("scale_10000", out_log[0], 16'h0002);
    check_eq("scale_ffff0000", out_log[1], 16'hFFFE);
`ifdef AXIS_FIR_SINK_ROUND_EN
    check_eq("scale_4000", out_log[2], 16'h0001);
`else
    check_eq("scale_4000", out_log[2], 16'h0000);
`endif
    check_eq("sat_clear", sat_flag, 1'b0);

    // Saturation, then sat_flag must stick through nominal traffic
    drive_sample(32'h7FFF_FFFF);
    drive_sample(32'h8000_0000);
    for (int i = 0; i < 100; i++) drive_sample(nominal());
    idle(1);
    drain();
    check_eq("sat_pos", out_log[3], 16'h7FFF);
    check_eq("sat_neg", out_log[4], 16'h8000);
    check_eq("sat_sticky", sat_flag, 1'b1);

    // Framing: 2000 back-to-back samples
    do_reset(3);
    m_tready = 1'b1;
    for (int i = 0; i < 2000; i++) drive_sample(nominal());
    idle(1);
    drain();
    check_eq("frame_tlasts", last_cnt, 2);
    check_eq("frame_first_last", first_last_idx, FRAME_LEN - 1);
    check_eq("frame_cnt_2", frame_cnt, 16'd2);

    // Backpressure: output stalled while 40 samples are offered
    m_tready = 1'b0;
    base_acc = acc_cnt;
    base_out = out_cnt;
    fork
      begin
        for (int i = 0; i < 40; i++) drive_sample(nominal());
        idle(1);
      end
      begin
        repeat (60) @(posedge aclk);
        @(negedge aclk);
        check_eq("bp_held", acc_cnt - base_acc, FIFO_DEPTH);
        check_eq("bp_tready", s_tready, 1'b0);
        check_eq("bp_tvalid", m_tvalid, 1'b1);
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();
    check_eq("bp_in_total", acc_cnt - base_acc, 40);
    check_eq("bp_out_total", out_cnt - base_out, 40);

    // Random throttling on both sides over three frames
    do_reset(2);
    done_t = 1'b0;
    fork
      begin
        for (int i = 0; i < 3 * FRAME_LEN; i++) begin
          drive_sample($urandom);
          if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
        end
        idle(1);
        done_t = 1'b1;
      end
      begin
        while (!done_t) begin
          @(posedge aclk);
          #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    check_eq("thr_tlasts", last_cnt, 3);
    check_eq("thr_frame_cnt", frame_cnt, 16'd3);

    // Reset in the middle of a frame flushes everything in flight
    m_tready = 1'b1;
    for (int i = 0; i < 500; i++) drive_sample(nominal());
    do_reset(4);
    for (int i = 0; i < FRAME_LEN; i++) drive_sample(nominal());
    idle(1);
    drain();
    check_eq("mid_rst_first_last", first_last_idx, FRAME_LEN - 1);
    check_eq("mid_rst_out_cnt", out_cnt, FRAME_LEN);
    check_eq("mid_rst_frame_cnt", frame_cnt, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
